// File: rtl/fir_tap_multiplier.sv
// Purpose: FIR sample delay line, writable coefficient bank and one registered signed product per tap.
// Latency: in_valid at edge N -> out_valid and multiplier_out valid from edge N+1 to edge N+2.
// Backpressure: none; accepts one sample per cycle, clear flushes taps and overrides in_valid.
module fir_tap_multiplier #(
    parameter  int TAPS     = 33,
    parameter  int DATABITS = 16,
    parameter  int COEFBITS = 16,
    parameter  int MULTBITS = DATABITS + COEFBITS,
    localparam int ADDRBITS = $clog2(TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATABITS-1:0] in_sample,
    input  logic                clear,
    input  logic                coef_we,
    input  logic [ADDRBITS-1:0] coef_addr,
    input  logic [COEFBITS-1:0] coef_data,
    output logic [MULTBITS-1:0] multiplier_out [0:TAPS-1],
    output logic                out_valid
);

    logic [DATABITS-1:0] r_tap  [0:TAPS-1];
    logic [COEFBITS-1:0] r_coef [0:TAPS-1];
    logic                r_vld;

    logic                w_accept;
    logic                w_coef_wr_ok;
    logic [MULTBITS-1:0] w_prod [0:TAPS-1];

    // A sample is taken only when no flush is requested in the same cycle.
    assign w_accept     = in_valid & ~clear;
    // Out-of-range addresses are dropped instead of aliasing onto a real tap.
    assign w_coef_wr_ok = coef_we & (int'(coef_addr) < TAPS);

    // Full-precision signed products: both operands are sign-extended to the
    // product width, so the low MULTBITS of the result are exact.
    genvar g;
    generate
        for (g = 0; g < TAPS; g++) begin : g_mult
            assign w_prod[g] = $signed({{COEFBITS{r_tap[g][DATABITS-1]}}, r_tap[g]})
                             * $signed({{DATABITS{r_coef[g][COEFBITS-1]}}, r_coef[g]});
        end
    endgenerate

    // Stage 1: delay line shift on accept, flush on clear, and the valid bit
    // that tells stage 2 a fresh tap set is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_tap[k] <= '0;
            r_vld <= 1'b0;
        end else begin
            if (clear) begin
                for (int k = 0; k < TAPS; k++) r_tap[k] <= '0;
            end else if (in_valid) begin
                r_tap[0] <= in_sample;
                for (int k = 1; k < TAPS; k++) r_tap[k] <= r_tap[k-1];
            end
            r_vld <= w_accept;
        end
    end

    // Coefficient bank; a write lands at this edge, so products computed at
    // this same edge still see the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (w_coef_wr_ok && (coef_addr == ADDRBITS'(k))) r_coef[k] <= coef_data;
            end
        end
    end

    // Stage 2: register the products one edge after an accepted sample; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) multiplier_out[k] <= '0;
            out_valid <= 1'b0;
        end else begin
            if (r_vld) begin
                for (int k = 0; k < TAPS; k++) multiplier_out[k] <= w_prod[k];
            end
            out_valid <= r_vld;
        end
    end

endmodule

// File: tb/tb_fir_tap_multiplier.sv
// Purpose: self-checking bench for fir_tap_multiplier using a queued expected-product scoreboard.
// Latency: expects each accepted sample's product set exactly one edge after acceptance.
// Backpressure: none; stimulus is driven one cycle at a time from a single process.
module tb_fir_tap_multiplier;

    localparam int TAPS     = 33;
    localparam int DATABITS = 16;
    localparam int COEFBITS = 16;
    localparam int MULTBITS = 32;
    localparam int ADDRBITS = 6;

    typedef logic [TAPS-1:0][MULTBITS-1:0] set_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [DATABITS-1:0] in_sample;
    logic                clear;
    logic                coef_we;
    logic [ADDRBITS-1:0] coef_addr;
    logic [COEFBITS-1:0] coef_data;
    logic [MULTBITS-1:0] multiplier_out [0:TAPS-1];
    logic                out_valid;

    fir_tap_multiplier #(
        .TAPS(TAPS), .DATABITS(DATABITS), .COEFBITS(COEFBITS), .MULTBITS(MULTBITS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
        .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .multiplier_out(multiplier_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference state
    logic signed [DATABITS-1:0] m_tap  [0:TAPS-1];
    logic signed [COEFBITS-1:0] m_coef [0:TAPS-1];
    set_t exp_q [$];
    set_t exp_out;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int vld_run  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic set_t model_products();
        set_t s;
        for (int k = 0; k < TAPS; k++) begin
            s[k] = 32'(longint'(m_tap[k]) * longint'(m_coef[k]));
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_tap[k]  = '0;
            m_coef[k] = '0;
        end
        exp_q.delete();
        exp_out = '0;
    endtask

    // Compare every output against the scoreboard; pops the set due this cycle.
    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
        if (out_valid) begin
            pulses++;
            vld_run++;
        end else begin
            vld_run = 0;
        end
        if (exp_q.size() > 0) exp_out = exp_q.pop_front();
        for (int k = 0; k < TAPS; k++) begin
            check($sformatf("prod[%0d]", k), multiplier_out[k], exp_out[k]);
        end
    endtask

    // One clock cycle: drive inputs, update the reference at the edge, check #1 later.
    task automatic cyc(input logic iv, input logic [DATABITS-1:0] s, input logic clr,
                       input logic we, input logic [ADDRBITS-1:0] a, input logic [COEFBITS-1:0] d);
        logic accept;
        set_t nxt;
        in_valid  = iv;
        in_sample = s;
        clear     = clr;
        coef_we   = we;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        accept = iv && !clr;
        if (clr) begin
            for (int k = 0; k < TAPS; k++) m_tap[k] = '0;
        end else if (iv) begin
            for (int k = TAPS-1; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = s;
        end
        if (we && (int'(a) < TAPS)) m_coef[a] = d;
        nxt = model_products();
        #1;
        check_outputs();
        if (accept) exp_q.push_back(nxt);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic sample(input logic [DATABITS-1:0] s);
        cyc(1'b1, s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr_coef(input int a, input logic [COEFBITS-1:0] d);
        cyc(1'b0, '0, 1'b0, 1'b1, ADDRBITS'(a), d);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_sample = '0; clear = 0;
        coef_we = 0; coef_addr = '0; coef_data = '0;
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        check_outputs();

        // 1: unit coefficients, three spaced samples
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'd1);
        pulses = 0;
        sample(16'd1); idle();
        sample(16'd2); idle();
        sample(16'd3); idle();
        check("t1_prod0", multiplier_out[0], 32'd3);
        check("t1_prod1", multiplier_out[1], 32'd2);
        check("t1_prod2", multiplier_out[2], 32'd1);
        check("t1_prod3", multiplier_out[3], 32'd0);
        check("t1_prod32", multiplier_out[32], 32'd0);
        idle();
        check("t1_pulses", pulses, 32'd3);

        // 2: coef[k]=k, 40 back-to-back samples
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'(k));
        for (int k = 0; k < 40; k++) sample(16'(k + 1));
        idle();
        check("t2_run", vld_run, 32'd40);
        check("t2_prod0", multiplier_out[0], 32'd0);
        check("t2_prod1", multiplier_out[1], 32'd39);
        check("t2_prod32", multiplier_out[32], 32'd256);
        idle();

        // 3: signed extremes
        wr_coef(0, 16'h8000);
        wr_coef(1, 16'h7FFF);
        sample(16'hFFFF);
        sample(16'h8000);
        idle();
        check("t3_prod0", multiplier_out[0], 32'h4000_0000);
        check("t3_prod1", multiplier_out[1], 32'hFFFF_8001);

        // 4: clear dominates in_valid
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'd2);
        for (int k = 0; k < TAPS; k++) sample(16'd5);
        idle();
        cyc(1'b1, 16'd9, 1'b1, 1'b0, '0, '0);
        idle();
        check("t4_no_vld", {31'd0, out_valid}, 32'd0);
        sample(16'd7);
        idle();
        check("t4_prod0", multiplier_out[0], 32'd14);
        check("t4_prod1", multiplier_out[1], 32'd0);
        check("t4_prod32", multiplier_out[32], 32'd0);

        // 5: write coinciding with in_valid, then an out-of-range write
        sample(16'd1); sample(16'd2); sample(16'd3);
        cyc(1'b1, 16'd10, 1'b0, 1'b1, 6'd3, 16'd4);
        idle();
        check("t5_prod3", multiplier_out[3], 32'd4);
        wr_coef(33, 16'd100);
        sample(16'd0);
        idle();
        check("t5_prod1", multiplier_out[1], 32'd20);
        check("t5_prod3b", multiplier_out[3], 32'd8);
        check("t5_prod4", multiplier_out[4], 32'd2);

        // 6: asynchronous reset with an out_valid pending
        sample(16'd11);
        sample(16'd12);
        check("t6_vld_before", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("t6_vld_rst", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < TAPS; k++) check($sformatf("t6_rst_prod[%0d]", k), multiplier_out[k], 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(); idle();
        sample(16'd5);
        idle();
        check("t6_zero_coef", multiplier_out[0], 32'd0);
        for (int k = 0; k < TAPS; k++) wr_coef(k, 16'd1);
        sample(16'd6);
        idle();
        check("t6_prod0", multiplier_out[0], 32'd6);
        check("t6_prod1", multiplier_out[1], 32'd5);
        check("t6_prod2", multiplier_out[2], 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
